pipeline_ctrl: RTL

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the enable and flush inputs of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) every cycle. It sequences three hazard types: load-use bubbles, taken-branch squashes, and multi-cycle EX operations (mul/div) tracked by an internal countdown FSM. It also honours a global data-memory wait that freezes the whole pipe.

---
 rtl/pipeline_ctrl_pkg.sv | 19 +
 rtl/pipeline_ctrl_load_use.sv | 29 ++
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    // Default register-index width (RV32: 32 architectural registers).
    localparam int unsigned REG_ADDR_W_DFLT = 5;

    // Default ceiling on multi-cycle EX latency; longer requests are clamped.
    localparam int unsigned MC_MAX_LAT_DFLT = 32;

    // Index of the hardwired-zero register; writes to it never create a hazard.
    localparam int unsigned X0_IDX = 0;

    // Controller FSM: normal flow, or counting down a multi-cycle EX op.
    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_live;

    // Only sources that are actually read can collide; x0 is never a real producer.
    always_comb begin
        rd_live = (ex_rd != REG_ADDR_W'(X0_IDX));
        rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
        hazard  = ex_is_load && rd_live && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Decides every
// cycle, combinationally, the load enables and NOP-flushes of the PC and the
// four pipeline registers. Priority: mem_wait > multi-cycle EX > taken
// branch > load-use.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DFLT,
    parameter int unsigned MC_MAX_LAT = MC_MAX_LAT_DFLT,
    parameter int unsigned CNT_W      = $clog2(MC_MAX_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_wait,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mc_start,
    input  logic [CNT_W-1:0]      ex_mc_lat,
    input  logic                  ex_branch_taken,
    output logic                  en_pc,
    output logic                  en_if_id,
    output logic                  en_id_ex,
    output logic                  en_ex_mem,
    output logic                  en_mem_wb,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  mc_busy
);

    localparam logic [CNT_W-1:0] LAT_CAP = CNT_W'(MC_MAX_LAT);
    localparam logic [CNT_W-1:0] LAT_TWO = CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] lat_clamped;
    logic             lu_hazard;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .hazard      (lu_hazard)
    );

    // Clamp the requested EX latency to the supported maximum.
    always_comb begin
        lat_clamped = (ex_mc_lat > LAT_CAP) ? LAT_CAP : ex_mc_lat;
    end

    // Output mux and next-state logic, evaluated in priority order.
    // The entry cycle counts as the first freeze, so rem is loaded with L-2:
    // L-1 freeze cycles total, then one release cycle in MC_WAIT with rem=0.
    always_comb begin
        en_pc        = 1'b1;
        en_if_id     = 1'b1;
        en_id_ex     = 1'b1;
        en_ex_mem    = 1'b1;
        en_mem_wb    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        state_d      = state_q;
        rem_d        = rem_q;

        if (rst) begin
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
            state_d   = RUN;
            rem_d     = '0;
        end else if (mem_wait) begin
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (state_q == RUN && ex_mc_start && lat_clamped >= LAT_TWO) begin
            en_pc        = 1'b0;
            en_if_id     = 1'b0;
            en_id_ex     = 1'b0;
            flush_ex_mem = 1'b1;
            rem_d        = lat_clamped - LAT_TWO;
            state_d      = MC_WAIT;
        end else if (state_q == MC_WAIT && rem_q != '0) begin
            en_pc        = 1'b0;
            en_if_id     = 1'b0;
            en_id_ex     = 1'b0;
            flush_ex_mem = 1'b1;
            rem_d        = rem_q - CNT_W'(1);
        end else begin
            state_d = RUN;
            if (ex_branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (lu_hazard) begin
                en_pc       = 1'b0;
                en_if_id    = 1'b0;
                flush_id_ex = 1'b1;
            end
        end
    end

    // State and remaining-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Busy flag taken straight from the registered state (glitch-free).
    always_comb begin
        mc_busy = (state_q == MC_WAIT);
    end

endmodule
